note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer_if.sv | 29 ++
 rtl/note_sequencer.sv | 140 ++++++++++++++
 tb/tb_note_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Record/playback bus for note_sequencer. Parameters must match the attached sequencer.
interface note_sequencer_if #(
  parameter int NOTE_W = 4,
  parameter int OCT_W  = 2,
  parameter int ADDR_W = 4
);
  logic              load_n;
  logic              playback;
  logic              clear;
  logic [NOTE_W-1:0] note_in;
  logic [OCT_W-1:0]  octave_in;
  logic [NOTE_W-1:0] note_out;
  logic [OCT_W-1:0]  octave_out;
  logic              note_valid;
  logic [ADDR_W:0]   count;
  logic              full;

  // note_valid qualifies note_out/octave_out on every cycle it is high; there is
  // no ready, so the consumer must accept each note for as long as it is held.
  modport master (
    output load_n, playback, clear, note_in, octave_in,
    input  note_out, octave_out, note_valid, count, full
  );

  modport slave (
    input  load_n, playback, clear, note_in, octave_in,
    output note_out, octave_out, note_valid, count, full
  );
endinterface

// File: rtl/note_sequencer.sv
// Records {note, octave} entries on load_n falling edges and plays them back, TICK_DIV cycles each.
// Define NOTE_SEQUENCER_LOOP_EN to add the loop_en input, which repeats the sequence.
module note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int NOTE_W   = 4,
  parameter int OCT_W    = 2,
  parameter int TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
`ifdef NOTE_SEQUENCER_LOOP_EN
  input  logic loop_en,
`endif
  note_sequencer_if.slave bus,
  output logic state_dbg
);
  localparam int HOLD_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(TICK_DIV - 1);
  localparam int ENT_W = NOTE_W + OCT_W;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t              state, state_d;
  logic [ADDR_W:0]     count, count_d;
  logic                full_r, full_d;
  logic [ADDR_W-1:0]   rd_idx, rd_idx_d, adv_idx;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic [NOTE_W-1:0]   note_r, note_d;
  logic [OCT_W-1:0]    oct_r, oct_d;
  logic                valid_r, valid_d;
  logic                load_q, play_q;
  logic                load_fall, play_rise, last, wr_en, loop_on;
  logic [ENT_W-1:0]    mem [DEPTH];

`ifdef NOTE_SEQUENCER_LOOP_EN
  assign loop_on = loop_en;
`else
  assign loop_on = 1'b0;
`endif

  assign load_fall = load_q & ~bus.load_n;
  assign play_rise = ~play_q & bus.playback;
  assign last      = ({1'b0, rd_idx} == (count - 1'b1));
  assign adv_idx   = last ? '0 : rd_idx + 1'b1;

  always_comb begin
    state_d  = state;
    count_d  = count;
    rd_idx_d = rd_idx;
    hold_d   = hold;
    note_d   = note_r;
    oct_d    = oct_r;
    valid_d  = valid_r;
    wr_en    = 1'b0;
    if (bus.clear) begin
      state_d  = IDLE;
      count_d  = '0;
      rd_idx_d = '0;
      hold_d   = '0;
      note_d   = '0;
      oct_d    = '0;
      valid_d  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A playback edge wins over a simultaneous record, which is dropped.
          if (play_rise) begin
            if (count != '0) begin
              state_d         = PLAY;
              rd_idx_d        = '0;
              {note_d, oct_d} = mem[0];
              valid_d         = 1'b1;
              hold_d          = HOLD_LOAD;
            end
          end else if (load_fall && !full_r) begin
            wr_en   = 1'b1;
            count_d = count + 1'b1;
          end
        end
        PLAY: begin
          if (play_rise || (hold == '0 && last && !loop_on)) begin
            state_d  = IDLE;
            rd_idx_d = '0;
            hold_d   = '0;
            note_d   = '0;
            oct_d    = '0;
            valid_d  = 1'b0;
          end else if (hold == '0) begin
            rd_idx_d        = adv_idx;
            {note_d, oct_d} = mem[adv_idx];
            hold_d          = HOLD_LOAD;
          end else begin
            hold_d = hold - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    full_d = (count_d == (ADDR_W+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      full_r  <= 1'b0;
      rd_idx  <= '0;
      hold    <= '0;
      note_r  <= '0;
      oct_r   <= '0;
      valid_r <= 1'b0;
      load_q  <= 1'b1;
      play_q  <= 1'b0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      full_r  <= full_d;
      rd_idx  <= rd_idx_d;
      hold    <= hold_d;
      note_r  <= note_d;
      oct_r   <= oct_d;
      valid_r <= valid_d;
      load_q  <= bus.load_n;
      play_q  <= bus.playback;
    end
  end

  // Storage survives reset and clear; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[ADDR_W-1:0]] <= {bus.note_in, bus.octave_in};
  end

  assign bus.note_out   = note_r;
  assign bus.octave_out = oct_r;
  assign bus.note_valid = valid_r;
  assign bus.count      = count;
  assign bus.full       = full_r;
  assign state_dbg      = (state == PLAY);
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with DEPTH=4, TICK_DIV=4; define NOTE_SEQUENCER_LOOP_EN to also cover looping.
module tb_note_sequencer;
  localparam int DEPTH = 4;
  localparam int TICK  = 4;

  logic clk = 1'b0;
  logic reset;
  logic state_dbg;
`ifdef NOTE_SEQUENCER_LOOP_EN
  logic loop_en;
`endif

  note_sequencer_if #(.NOTE_W(4), .OCT_W(2), .ADDR_W(2)) bus ();

  note_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(2), .NOTE_W(4), .OCT_W(2), .TICK_DIV(TICK)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef NOTE_SEQUENCER_LOOP_EN
    .loop_en(loop_en),
`endif
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];
  logic [5:0] model_mem[DEPTH];
  int         model_cnt = 0;

  typedef struct {
    logic       load_n, playback, clear;
    logic [3:0] note;
    logic [1:0] oct;
    logic [2:0] exp_count;
    logic       exp_full, exp_valid;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic record(input logic [3:0] n, input logic [1:0] o);
    @(negedge clk);
    bus.note_in = n; bus.octave_in = o; bus.load_n = 1'b0;
    @(negedge clk);
    bus.load_n = 1'b1;
    if (model_cnt < DEPTH) begin
      model_mem[model_cnt] = {n, o};
      model_cnt++;
    end
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int i = 0; i < model_cnt; i++) exp_q.push_back(model_mem[i]);
  endtask

  // Starts playback and pops one expected entry per TICK cycles of output.
  task automatic play_check(input int n_entries, input bit expect_end, input int load_at);
    int cyc = 0;
    logic [5:0] exp;
    logic [31:0] act;
    @(negedge clk);
    bus.playback = 1'b1;
    for (int e = 0; e < n_entries; e++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
      act = {26'd0, exp};
      for (int k = 0; k < TICK; k++) begin
        @(posedge clk); #1;
        cyc++;
        if (cyc == 1) bus.playback = 1'b0;
        if (cyc == load_at) bus.load_n = 1'b0;
        if (cyc == load_at + 1) bus.load_n = 1'b1;
        if (!bus.note_valid) act = 32'hdead;
        else if ({bus.note_out, bus.octave_out} !== exp && act == {26'd0, exp})
          act = {26'd0, bus.note_out, bus.octave_out};
      end
      check($sformatf("entry%0d", e), act, {26'd0, exp});
    end
    if (expect_end) begin
      @(posedge clk); #1;
      check("end_valid", bus.note_valid, 0);
      check("end_note", {bus.note_out, bus.octave_out}, 0);
      check("end_state", state_dbg, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.load_n = 1'b1; bus.playback = 1'b0; bus.clear = 1'b0;
    bus.note_in = '0; bus.octave_in = '0;
`ifdef NOTE_SEQUENCER_LOOP_EN
    loop_en = 1'b0;
`endif
    //                load play clr note oct  cnt full valid
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd1, 2'd0, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd1, 2'd0, 3'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd2, 2'd1, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd9, 2'd3, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd9, 2'd3, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd3, 2'd2, 3'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd3, 2'd2, 3'd3, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd4, 2'd0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd4, 2'd0, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd5, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd5, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 4'd6, 2'd1, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd6, 2'd1, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 4'd6, 2'd1, 3'd0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.note_valid, 0);
    check("rst_note", {bus.note_out, bus.octave_out}, 0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.load_n = vecs[i].load_n; bus.playback = vecs[i].playback; bus.clear = vecs[i].clear;
      bus.note_in = vecs[i].note; bus.octave_in = vecs[i].oct;
      @(posedge clk); #1;
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
      check($sformatf("vec%0d_full", i), bus.full, vecs[i].exp_full);
      check($sformatf("vec%0d_valid", i), bus.note_valid, vecs[i].exp_valid);
    end
    @(negedge clk);
    bus.clear = 1'b0; bus.load_n = 1'b1; bus.playback = 1'b0;

    // three notes, full playback
    record(4'd1, 2'd0); record(4'd2, 2'd1); record(4'd3, 2'd2);
    check("a_count", bus.count, 3);
    check("a_full", bus.full, 0);
    fill_exp();
    play_check(3, 1'b1, 0);
    check("a_count_after", bus.count, 3);

    // overfill: fifth record dropped
    record(4'd4, 2'd3); record(4'd5, 2'd0);
    check("b_count", bus.count, 4);
    check("b_full", bus.full, 1);
    fill_exp();
    play_check(4, 1'b1, 0);

    // abort with a second playback edge six cycles in
    @(negedge clk);
    bus.playback = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.playback = 1'b0;
    end
    bus.playback = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", bus.note_valid, 0);
    check("abort_note", {bus.note_out, bus.octave_out}, 0);
    check("abort_count", bus.count, 4);
    bus.playback = 1'b0;

    // clear, one entry, record attempt during playback is dropped
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    check("clr_count", bus.count, 0);
    check("clr_full", bus.full, 0);
    bus.clear = 1'b0;
    model_cnt = 0;
    record(4'd6, 2'd1);
    fill_exp();
    play_check(1, 1'b1, 2);
    check("d_count", bus.count, 1);

    // simultaneous record and playback edges: playback only
    @(negedge clk);
    bus.playback = 1'b1; bus.load_n = 1'b0; bus.note_in = 4'd7; bus.octave_in = 2'd3;
    @(posedge clk); #1;
    check("e_valid", bus.note_valid, 1);
    check("e_note", {bus.note_out, bus.octave_out}, {4'd6, 2'd1});
    check("e_count", bus.count, 1);
    bus.playback = 1'b0; bus.load_n = 1'b1;
    repeat (TICK) @(posedge clk);
    #1;
    check("e_end_valid", bus.note_valid, 0);
    check("e_end_count", bus.count, 1);

    // reset during playback acts immediately
    @(negedge clk);
    bus.playback = 1'b1;
    @(posedge clk); #1;
    bus.playback = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("g_valid", bus.note_valid, 0);
    check("g_note", {bus.note_out, bus.octave_out}, 0);
    check("g_count", bus.count, 0);
    check("g_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    bus.playback = 1'b1;
    @(posedge clk); #1;
    check("g_empty_play_valid", bus.note_valid, 0);
    check("g_empty_play_state", state_dbg, 0);
    bus.playback = 1'b0;

`ifdef NOTE_SEQUENCER_LOOP_EN
    loop_en = 1'b1;
    record(4'd1, 2'd0); record(4'd2, 2'd1);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(model_mem[i % 2]);
    play_check(5, 1'b0, 0);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    check("loop_clr_valid", bus.note_valid, 0);
    check("loop_clr_count", bus.count, 0);
    bus.clear = 1'b0;
    loop_en = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
